// File: rtl/hamming_arbiter.sv
// Round-robin arbiter sharing one Hamming(7,4) encoder among N nibble requesters.
// One request is in flight at a time; an encoder that never answers is abandoned after TIMEOUT cycles.
module hamming_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [4*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic [3:0]       enc_bits,
    output logic             enc_start,
    input  logic             enc_done,
    input  logic [6:0]       enc_byte,
    output logic             out_valid,
    output logic [6:0]       out_byte,
    output logic [IW-1:0]    out_id,
    input  logic             out_ready,
    output logic             err_timeout
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   gnt_reg;
    logic [3:0]      nib_reg;
    logic [6:0]      code_reg;
    logic [TW-1:0]   timer_reg;

    logic [N-1:0]    rot_valid;
    logic            any_req;
    int              offset;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   next_ptr;
    logic            timed_out;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Requests rotated so that position 0 is the current round-robin pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_valid[gi] = req_valid[wrap_add(ptr_reg, gi)];
        end
    endgenerate

    always_comb begin
        any_req = 1'b0;
        offset  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                any_req = 1'b1;
                offset  = k;
            end
        end
        grant = wrap_add(ptr_reg, offset);
    end

    assign next_ptr  = wrap_add(gnt_reg, 1);
    assign timed_out = (state_reg == WAIT) && !enc_done && (timer_reg == TLAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (enc_done) state_next = OUTPUT;
                     else if (timed_out) state_next = IDLE;
            OUTPUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            nib_reg   <= '0;
            code_reg  <= '0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (any_req) begin
                    gnt_reg <= grant;
                    nib_reg <= req_data[int'(grant) * 4 +: 4];
                end
                ISSUE: timer_reg <= '0;
                WAIT: begin
                    if (enc_done) code_reg <= enc_byte;
                    else if (timed_out) ptr_reg <= next_ptr;
                    else timer_reg <= timer_reg + 1'b1;
                end
                OUTPUT: if (out_ready) ptr_reg <= next_ptr;
                default: ;
            endcase
        end
    end

    // Acceptance is gated by reset so nothing is handed out while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && any_req && !reset) req_ready[grant] = 1'b1;
    end

    assign enc_start   = (state_reg == ISSUE);
    assign enc_bits    = nib_reg;
    assign out_valid   = (state_reg == OUTPUT);
    assign out_byte    = code_reg;
    assign out_id      = gnt_reg;
    assign err_timeout = timed_out;

endmodule

// File: tb/tb_hamming_arbiter.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// rule-based reference model of the arbitration / encode / delivery sequence.
module tb_hamming_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [4*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [3:0]     enc_bits;
    logic           enc_start;
    logic           enc_done;
    logic [6:0]     enc_byte;
    logic           out_valid;
    logic [6:0]     out_byte;
    logic [1:0]     out_id;
    logic           out_ready;
    logic           err_timeout;

    hamming_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .enc_bits(enc_bits), .enc_start(enc_start),
        .enc_done(enc_done), .enc_byte(enc_byte), .out_valid(out_valid),
        .out_byte(out_byte), .out_id(out_id), .out_ready(out_ready),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stimulus knobs
    logic [N-1:0]   d_req_valid = '0;
    logic [4*N-1:0] d_req_data = '0;
    logic           d_out_ready = 1'b1;
    int             enc_plan = -1;     // -1 random latency, 0 never answers, else latency
    int             code_fixed = -1;   // -1 random codeword
    bit             spurious_en = 0;

    // encoder behaviour and observation
    int         enc_cd = -1;
    logic [6:0] code_next = '0;
    int         cyc = 0;
    int         last_start = 0;
    int         to_count = 0;
    int         ov_count = 0;
    int         glog[$];

    // reference model
    bit         m_busy, m_issue, m_have;
    int         m_owner, m_ptr, m_wait;
    logic [3:0] m_nib;
    logic [6:0] m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_busy = 0; m_issue = 0; m_have = 0;
        m_owner = 0; m_ptr = 0; m_wait = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_enc_start"}, 32'(enc_start), 0);
        chk({tag, "_enc_bits"}, 32'(enc_bits), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_byte"}, 32'(out_byte), 0);
        chk({tag, "_out_id"}, 32'(out_id), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
    endtask

    function automatic int pick_latency();
        int r;
        r = $urandom_range(9);
        case (r)
            0: return 16;
            1: return 17;
            2: return 0;
            3: return $urandom_range(20, 1);
            default: return $urandom_range(4, 1);
        endcase
    endfunction

    task automatic model_check();
        logic [N-1:0] e_ready;
        bit e_start, e_ov, e_to, in_wait, found;
        int idx;
        e_ready = '0; e_start = 0; e_ov = 0; e_to = 0; found = 0;
        in_wait = m_busy && !m_issue && !m_have;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1;
                    e_ready[idx] = 1'b1;
                    m_busy = 1; m_issue = 1; m_owner = idx;
                    m_nib = req_data[4*idx +: 4];
                end
            end
        end else if (m_issue) begin
            int lat;
            e_start = 1; m_issue = 0; m_wait = 0;
            lat = (enc_plan == -1) ? pick_latency() : enc_plan;
            enc_cd = (lat == 0) ? -1 : lat;
            code_next = (code_fixed == -1) ? 7'($urandom) : 7'(code_fixed);
            last_start = cyc;
        end else if (!m_have) begin
            if (enc_done) begin
                m_have = 1; m_code = enc_byte;
            end else if (m_wait == TO - 1) begin
                e_to = 1; m_busy = 0; m_ptr = (m_owner + 1) % N;
            end else begin
                m_wait++;
            end
        end else begin
            e_ov = 1;
            if (out_ready) begin
                m_busy = 0; m_have = 0; m_ptr = (m_owner + 1) % N;
            end
        end

        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("enc_start", 32'(enc_start), 32'(e_start));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("err_timeout", 32'(err_timeout), 32'(e_to));
        if (e_start || in_wait) chk("enc_bits", 32'(enc_bits), 32'(m_nib));
        if (e_ov) begin
            chk("out_byte", 32'(out_byte), 32'(m_code));
            chk("out_id", 32'(out_id), 32'(m_owner));
        end
        if (err_timeout === 1'b1) begin
            to_count++;
            chk("timeout_delay", 32'(cyc - last_start), TO);
        end
        if (out_valid === 1'b1 && out_ready) ov_count++;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) glog.push_back(i);
    endtask

    // Entered and left at posedge+1: drive, check at negedge, advance to next posedge.
    task automatic step();
        cyc++;
        req_valid = d_req_valid;
        req_data  = d_req_data;
        out_ready = d_out_ready;
        enc_done  = 1'b0;
        if (enc_cd > 0) begin
            enc_cd--;
            if (enc_cd == 0) begin
                enc_done = 1'b1;
                enc_cd = -1;
            end
        end else if (spurious_en && $urandom_range(15) == 0) begin
            enc_done = 1'b1;
        end
        enc_byte = enc_done ? code_next : 7'($urandom);
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset mid-cycle so the asynchronous path is observed before any clock edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_reset_outputs(tag);
        model_init();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n0, g;
        reset = 1'b1;
        req_valid = '1; req_data = '0; out_ready = 1'b0;
        enc_done = 1'b0; enc_byte = '0;
        #1 check_reset_outputs("por");
        model_init();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // single request from requester 1
        d_req_valid = 4'b0010; d_req_data = 16'h00B0; enc_plan = 3; code_fixed = 7'h55;
        step();
        chk("single_grant", 32'(glog.size() > 0 ? glog[0] : -1), 1);
        d_req_valid = '0;
        steps(8);
        chk("single_delivered", 32'(ov_count), 1);

        // fairness: all requesting from reset, one-cycle encoder
        do_reset("rst1");
        glog.delete();
        d_req_valid = 4'b1111; d_req_data = 16'h7A3C; enc_plan = 1; code_fixed = -1;
        steps(24);
        chk("rr_count", 32'(glog.size() >= 5), 1);
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(i < glog.size() ? glog[i] : -1), i % N);

        // backpressure while all keep requesting
        d_out_ready = 1'b0; enc_plan = 2;
        steps(12);
        d_out_ready = 1'b1;
        steps(6);

        // timeout: requester 2 alone, encoder never answers
        d_req_valid = '0;
        steps(6);
        glog.delete();
        n0 = to_count;
        d_req_valid = 4'b0100; d_req_data = 16'h0500; enc_plan = 0;
        step();
        d_req_valid = '0;
        steps(22);
        chk("timeout_once", 32'(to_count - n0), 1);
        d_req_valid = 4'b1111; enc_plan = 1;
        steps(2);
        g = (glog.size() > 1) ? glog[1] : -1;
        chk("after_timeout_grant", 32'(g), 3);
        d_req_valid = '0;
        steps(8);

        // enc_done on the final timeout cycle wins
        n0 = to_count;
        ov_count = 0;
        d_req_valid = 4'b0001; d_req_data = 16'h000E; enc_plan = 16;
        step();
        d_req_valid = '0;
        steps(22);
        chk("race_no_timeout", 32'(to_count - n0), 0);
        chk("race_delivered", 32'(ov_count), 1);

        // reset in the middle of WAIT; the late enc_done must be ignored
        d_req_valid = 4'b1000; d_req_data = 16'h9000; enc_plan = 6;
        step();
        d_req_valid = '0;
        steps(3);
        do_reset("rst_wait");
        glog.delete();
        steps(8);
        d_req_valid = 4'b1111; enc_plan = 1;
        step();
        chk("post_reset_grant", 32'(glog.size() > 0 ? glog[0] : -1), 0);
        d_req_valid = '0;
        steps(6);

        // random traffic
        enc_plan = -1; spurious_en = 1;
        for (int i = 0; i < 1500; i++) begin
            d_req_valid = ($urandom_range(3) == 0) ? '0 : N'($urandom);
            d_req_data  = 16'($urandom);
            d_out_ready = ($urandom_range(3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hamming_arbiter.md
HAMMING_ARBITER -- requirements
Module: hamming_arbiter

Interface
REQ-001 Parameter N, default 4, number of nibble requesters sharing one Hamming(7,4) encoder.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for the encoder before abandoning a request.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N  requester i has a 4-bit nibble pending.
REQ-006 req_data  input  4*N  nibble of requester i, bits [4i+3:4i].
REQ-007 req_ready  output  N  one-hot acceptance pulse to the granted requester.
REQ-008 enc_bits  output  4  nibble presented to the encoder.
REQ-009 enc_start  output  1  one-cycle encode command.
REQ-010 enc_done  input  1  encoder result valid, one-cycle pulse.
REQ-011 enc_byte  input  7  encoder codeword, sampled when enc_done=1.
REQ-012 out_valid  output  1  codeword available downstream.
REQ-013 out_byte  output  7  codeword.
REQ-014 out_id  output  clog2(N) (min 1)  index of originating requester.
REQ-015 out_ready  input  1  downstream accepts codeword.
REQ-016 err_timeout  output  1  one-cycle pulse on encoder timeout.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, OUTPUT; exactly one request in flight.
REQ-018 IDLE: if any req_valid, grant first set bit searching ptr, ptr+1, ... mod N; assert req_ready[g] combinationally that cycle; latch nibble and g; go to ISSUE.
REQ-019 IDLE with no req_valid: req_ready=0, stay in IDLE.
REQ-020 ISSUE: enc_start=1 for exactly one cycle, enc_bits=latched nibble; clear timer; go to WAIT.
REQ-021 enc_bits holds latched nibble from ISSUE through end of WAIT.
REQ-022 WAIT: on enc_done=1 latch enc_byte into out_byte, go to OUTPUT; otherwise increment timer.
REQ-023 WAIT: when timer reaches TIMEOUT-1 without enc_done, pulse err_timeout one cycle, set ptr=(g+1) mod N, go to IDLE; nibble is dropped.
REQ-024 enc_done and timeout in same cycle: enc_done wins, no err_timeout.
REQ-025 enc_done outside WAIT is ignored.
REQ-026 OUTPUT: out_valid=1, out_byte/out_id stable until out_ready=1; on out_valid&out_ready set ptr=(g+1) mod N, go to IDLE next cycle.
REQ-027 Round-robin fairness: a continuously requesting requester is granted within N grants.
REQ-028 ptr wraps N-1 -> 0; N=1 always grants requester 0.
REQ-029 Minimum request-to-request spacing is 4 cycles (IDLE, ISSUE, WAIT>=1, OUTPUT>=1).

Reset
REQ-030 Reset asserted at any time, including mid-WAIT or OUTPUT, returns FSM to IDLE immediately without waiting for clk; in-flight request discarded.
REQ-031 Reset values: req_ready=0, enc_start=0, enc_bits=0, out_valid=0, out_byte=0, out_id=0, err_timeout=0, ptr=0, timer=0.
REQ-032 First grant after reset searches from requester 0.

Verification
REQ-033 Single request: req_valid=4'b0010, req_data[7:4]=4'b1011, encoder model returns 7'h55 with enc_done 3 cycles after enc_start, out_ready=1 -> req_ready=4'b0010 one cycle, enc_bits=4'b1011, out_valid with out_byte=7'h55, out_id=1.
REQ-034 All four requesting continuously, encoder 1-cycle latency -> grant order 0,1,2,3,0; no requester skipped.
REQ-035 Backpressure: out_ready=0 for 5 cycles in OUTPUT -> out_valid, out_byte, out_id constant; no new req_ready until handshake completes.
REQ-036 Timeout: encoder never answers, TIMEOUT=16 -> err_timeout pulses exactly once 16 cycles after enc_start, no out_valid, next grant goes to requester g+1.
REQ-037 Simultaneous enc_done with final timeout cycle -> codeword output, err_timeout stays 0.
REQ-038 Reset asserted mid-WAIT between clock edges -> all outputs at reset values immediately; late enc_done ignored; next grant from requester 0.
